// File: rtl/core_sequencer_pkg.sv
// Shared types for the stage sequencer: FSM states, error causes, stage indices.
// Latency: n/a; backpressure: n/a.
package core_sequencer_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_X = 2;
    localparam int STG_M = 3;
    localparam int STG_W = 4;
    localparam int NUM_STAGES = 5;

    typedef enum logic [3:0] {
        F_ISSUE,
        F_WAIT,
        D_ISSUE,
        D_WAIT,
        X_ISSUE,
        X_WAIT,
        M_ISSUE,
        M_WAIT,
        W_ISSUE,
        W_WAIT,
        HALTED,
        ERROR
    } stage_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_MISALIGN = 2'd2
    } err_cause_t;

    function automatic logic is_wait_state(input stage_state_t s);
        return (s == F_WAIT) || (s == D_WAIT) || (s == X_WAIT) ||
               (s == M_WAIT) || (s == W_WAIT);
    endfunction

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Enabled/completed handshake between the sequencer and the five stage units.
// Latency: n/a; backpressure: a stage holds the sequencer in WAIT until it pulses completed.
interface core_sequencer_if;

    logic        fetch_enabled;
    logic        fetch_completed;
    logic        decode_enabled;
    logic        decode_completed;
    logic        exec_enabled;
    logic        exec_completed;
    logic        mem_enabled;
    logic        mem_completed;
    logic        wb_enabled;
    logic        wb_completed;
    logic        is_mem_op;
    logic        is_jump_chosen;
    logic [31:0] jump_dest;

    modport master (
        output fetch_enabled, decode_enabled, exec_enabled, mem_enabled, wb_enabled,
        input  fetch_completed, decode_completed, exec_completed, mem_completed, wb_completed,
        input  is_mem_op, is_jump_chosen, jump_dest
    );

    modport slave (
        input  fetch_enabled, decode_enabled, exec_enabled, mem_enabled, wb_enabled,
        output fetch_completed, decode_completed, exec_completed, mem_completed, wb_completed,
        output is_mem_op, is_jump_chosen, jump_dest
    );

endinterface

// File: rtl/core_sequencer_stage_watchdog.sv
// Counts consecutive WAIT cycles of one stage; expired marks the LIMIT-th such cycle.
// Latency: expired is combinational from the count; backpressure: none. LIMIT=0 disables.
module core_sequencer_stage_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam bit          ENABLED = (LIMIT != 0);
    localparam logic [31:0] LAST    = 32'(LIMIT) - 32'd1;

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && ENABLED) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of earlier WAIT cycles, so this is the LIMIT-th one.
    assign expired = ENABLED && count_en && (cnt_q == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Sequences fetch/decode/execute/mem/writeback for one instruction at a time and owns the PC.
// Latency: 2+ cycles per stage; backpressure: each stage stalls the FSM until its completed pulse.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    halt_req,
    core_sequencer_if.master        sif,
    output logic [31:0]             pc,
    output logic [31:0]             instret,
    output logic                    halted,
    output logic                    error,
    output logic [1:0]              err_cause
);

    stage_state_t           state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            next_pc_q, next_pc_d;
    logic [31:0]            instret_q, instret_d;
    logic                   is_mem_q, is_mem_d;
    err_cause_t             err_cause_q, err_cause_d;
    logic [NUM_STAGES-1:0]  en_q, en_d;
    logic                   halted_q, halted_d;
    logic                   error_q, error_d;

    logic                   wd_clear;
    logic                   wd_count;
    logic                   wd_expired;

    assign wd_count = is_wait_state(state_q);
    assign wd_clear = !wd_count;

    core_sequencer_stage_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (wd_clear),
        .count_en (wd_count),
        .expired  (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        next_pc_d   = next_pc_q;
        instret_d   = instret_q;
        is_mem_d    = is_mem_q;
        err_cause_d = err_cause_q;

        unique case (state_q)
            // Reset leaves the fetch enable low, so the first F_ISSUE lingers one cycle to pulse it.
            F_ISSUE: if (en_q[STG_F]) state_d = F_WAIT;
            D_ISSUE: state_d = D_WAIT;
            X_ISSUE: state_d = X_WAIT;
            M_ISSUE: state_d = M_WAIT;
            W_ISSUE: state_d = W_WAIT;

            F_WAIT: begin
                if (sif.fetch_completed) begin
                    state_d = D_ISSUE;
                end else if (wd_expired) begin
                    state_d     = ERROR;
                    err_cause_d = ERR_TIMEOUT;
                end
            end

            D_WAIT: begin
                if (sif.decode_completed) begin
                    is_mem_d = sif.is_mem_op;
                    state_d  = X_ISSUE;
                end else if (wd_expired) begin
                    state_d     = ERROR;
                    err_cause_d = ERR_TIMEOUT;
                end
            end

            X_WAIT: begin
                if (sif.exec_completed) begin
                    if (sif.is_jump_chosen && !is_aligned(sif.jump_dest)) begin
                        state_d     = ERROR;
                        err_cause_d = ERR_MISALIGN;
                    end else begin
                        next_pc_d = sif.is_jump_chosen ? sif.jump_dest : (pc_q + INSTR_BYTES);
                        state_d   = is_mem_q ? M_ISSUE : W_ISSUE;
                    end
                end else if (wd_expired) begin
                    state_d     = ERROR;
                    err_cause_d = ERR_TIMEOUT;
                end
            end

            M_WAIT: begin
                if (sif.mem_completed) begin
                    state_d = W_ISSUE;
                end else if (wd_expired) begin
                    state_d     = ERROR;
                    err_cause_d = ERR_TIMEOUT;
                end
            end

            W_WAIT: begin
                if (sif.wb_completed) begin
                    pc_d      = next_pc_q;
                    instret_d = instret_q + 32'd1;
                    state_d   = halt_req ? HALTED : F_ISSUE;
                end else if (wd_expired) begin
                    state_d     = ERROR;
                    err_cause_d = ERR_TIMEOUT;
                end
            end

            HALTED: if (!halt_req) state_d = F_ISSUE;

            ERROR: state_d = ERROR;

            default: state_d = state_q;
        endcase

        // Outputs are flopped from the next state so they align with the state they describe.
        en_d[STG_F] = (state_d == F_ISSUE);
        en_d[STG_D] = (state_d == D_ISSUE);
        en_d[STG_X] = (state_d == X_ISSUE);
        en_d[STG_M] = (state_d == M_ISSUE);
        en_d[STG_W] = (state_d == W_ISSUE);
        halted_d    = (state_d == HALTED);
        error_d     = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= F_ISSUE;
            pc_q        <= RESET_PC;
            next_pc_q   <= RESET_PC;
            instret_q   <= '0;
            is_mem_q    <= 1'b0;
            err_cause_q <= ERR_NONE;
            en_q        <= '0;
            halted_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            next_pc_q   <= next_pc_d;
            instret_q   <= instret_d;
            is_mem_q    <= is_mem_d;
            err_cause_q <= err_cause_d;
            en_q        <= en_d;
            halted_q    <= halted_d;
            error_q     <= error_d;
        end
    end

    assign sif.fetch_enabled  = en_q[STG_F];
    assign sif.decode_enabled = en_q[STG_D];
    assign sif.exec_enabled   = en_q[STG_X];
    assign sif.mem_enabled    = en_q[STG_M];
    assign sif.wb_enabled     = en_q[STG_W];

    assign pc        = pc_q;
    assign instret   = instret_q;
    assign halted    = halted_q;
    assign error     = error_q;
    assign err_cause = err_cause_q;

endmodule
